soma_serial: RTL and testbench



---
 rtl/soma_pkg.sv | 12 +
 rtl/soma_serial_if.sv | 27 ++
 rtl/soma_bit.sv | 13 +
 rtl/soma_serial.sv | 74 +++++++
 tb/tb_soma_serial.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/soma_pkg.sv
// soma_pkg: shared types, defaults and helpers for the bit-serial adder
package soma_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int SOMA_WIDTH_DEF = 8;

    function automatic int count_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/soma_serial_if.sv
// soma_serial_if: operand/result valid-ready bus; ovf present only with SOMA_OVERFLOW_EN
interface soma_serial_if import soma_pkg::*; #(parameter int WIDTH = SOMA_WIDTH_DEF);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SOMA_OVERFLOW_EN
    logic             ovf;

    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout);
`endif

endinterface

// File: rtl/soma_bit.sv
// soma_bit: combinational full-adder cell
module soma_bit (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ c;
    assign co = (x & y) | (c & (x ^ y));

endmodule

// File: rtl/soma_serial.sv
// soma_serial: bit-serial WIDTH-bit adder, LSB first; signed overflow output with SOMA_OVERFLOW_EN
module soma_serial import soma_pkg::*; #(
    parameter int WIDTH = SOMA_WIDTH_DEF
) (
    input logic         clk,
    input logic         rst_n,
    soma_serial_if.slave bus
);

    localparam int            CW   = count_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic [CW-1:0]    count;
    logic             s;
    logic             co;
`ifdef SOMA_OVERFLOW_EN
    logic             c_msb;
`endif

    soma_bit u_bit (.x(a_q[0]), .y(b_q[0]), .c(carry), .s(s), .co(co));

    // in_ready is masked by rst_n so nothing is accepted while reset is held
    assign bus.in_ready  = rst_n && state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.sum       = sum_q;
    assign bus.cout      = carry;
`ifdef SOMA_OVERFLOW_EN
    assign bus.ovf       = c_msb ^ carry;
`endif

    // Control FSM and serial datapath: capture, WIDTH shift/add steps, hold until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            carry <= 1'b0;
            count <= '0;
`ifdef SOMA_OVERFLOW_EN
            c_msb <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_q   <= bus.a;
                    b_q   <= bus.b;
                    carry <= bus.cin;
                    count <= '0;
                    state <= RUN;
                end
                RUN: begin
                    sum_q <= {s, sum_q[WIDTH-1:1]};
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    carry <= co;
                    count <= count + 1'b1;
`ifdef SOMA_OVERFLOW_EN
                    if (count == LAST) c_msb <= carry;
`endif
                    if (count == LAST) state <= DONE;
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_soma_serial.sv
// tb_soma_serial: self-checking bench for soma_serial (set SOMA_OVERFLOW_EN to also check ovf)
module tb_soma_serial;
    import soma_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    soma_serial_if #(.WIDTH(W)) bus ();
    soma_serial #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int r;
        r = int'($signed(a)) + int'($signed(b)) + int'(c);
        return r > (2 ** (W - 1)) - 1 || r < -(2 ** (W - 1));
    endfunction

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input string nm);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = c;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s accept: in_ready=%b required 1", nm, bus.in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input string nm);
        int lat = 0;
        logic [W:0] exp;
        exp = ref_add(a, b, c);
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        compared++;
        if (lat != W) begin
            mismatched++;
            $display("FAIL %s latency: got %0d required %0d", nm, lat, W);
        end
        compared++;
        if ({bus.cout, bus.sum} !== exp) begin
            mismatched++;
            $display("FAIL %s result: {cout,sum}=%h required %h", nm, {bus.cout, bus.sum}, exp);
        end
`ifdef SOMA_OVERFLOW_EN
        compared++;
        if (bus.ovf !== ref_ovf(a, b, c)) begin
            mismatched++;
            $display("FAIL %s ovf: got %b required %b", nm, bus.ovf, ref_ovf(a, b, c));
        end
`endif
    endtask

    task automatic release_result(input string nm);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        compared++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s release: out_valid=%b in_ready=%b required 0/1", nm, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input string nm);
        accept(a, b, c, nm);
        check_result(a, b, c, nm);
        release_result(nm);
    endtask

    task automatic check_quiet(input int cycles, input string nm);
        int bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL %s quiet: out_valid high on %0d cycles required 0", nm, bad);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.sum !== '0 || bus.cout !== 1'b0) begin
            mismatched++;
            $display("FAIL reset: out_valid=%b in_ready=%b sum=%h cout=%b required 0/0/00/0",
                     bus.out_valid, bus.in_ready, bus.sum, bus.cout);
        end
`ifdef SOMA_OVERFLOW_EN
        compared++;
        if (bus.ovf !== 1'b0) begin
            mismatched++;
            $display("FAIL reset ovf: got %b required 0", bus.ovf);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset release: in_ready=%b required 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        op(8'h3C, 8'h05, 1'b0, "add_3c_05");
        op(8'hFF, 8'h01, 1'b0, "wrap_ff_01");
        op(8'h7F, 8'h01, 1'b0, "ovf_7f_01");
        op(8'h80, 8'h80, 1'b1, "ovf_80_80_c");
        op(8'h00, 8'h00, 1'b1, "cin_only");
        op(8'hFF, 8'hFF, 1'b1, "all_ones");
    endtask

    task automatic test_backpressure();
        int bad = 0;
        logic [W:0] exp;
        exp = ref_add(8'hA7, 8'h6E, 1'b1);
        accept(8'hA7, 8'h6E, 1'b1, "bp");
        check_result(8'hA7, 8'h6E, 1'b1, "bp");
        repeat (5) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.a = 8'h11;
            bus.b = 8'h22;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || {bus.cout, bus.sum} !== exp) bad++;
        end
        compared++;
        if (bad != 0) begin
            mismatched++;
            $display("FAIL bp hold: %0d unstable cycles required 0", bad);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        compared++;
        if ({bus.cout, bus.sum} !== exp || bus.out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL bp release: {cout,sum}=%h out_valid=%b required %h/1", {bus.cout, bus.sum}, bus.out_valid, exp);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_quiet(W + 2, "bp_no_queue");
    endtask

    task automatic test_reset_mid_run();
        accept(8'h5A, 8'h33, 1'b0, "mid_rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        compared++;
        if (bus.out_valid !== 1'b0 || bus.sum !== '0 || bus.in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_rst: out_valid=%b sum=%h in_ready=%b required 0/00/0", bus.out_valid, bus.sum, bus.in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_quiet(W + 2, "mid_rst_after");
        op(8'h10, 8'h20, 1'b1, "post_rst");
    endtask

    task automatic test_random();
        logic [W:0] q[$];
        logic       qo[$];
        logic [W:0] exp;
        logic       eo;
        int acc = 0;
        int cyc = 0;
        while ((acc < 1000 || q.size() > 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            bus.in_valid = acc < 1000 && $urandom_range(0, 3) != 0;
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            bus.cin = 1'($urandom);
            bus.out_ready = $urandom_range(0, 3) != 0;
            if (bus.out_valid && bus.out_ready) begin
                compared++;
                if (q.size() == 0) begin
                    mismatched++;
                    $display("FAIL rand dup: result %h with no pending operation", {bus.cout, bus.sum});
                end else begin
                    exp = q.pop_front();
                    eo = qo.pop_front();
                    if ({bus.cout, bus.sum} !== exp) begin
                        mismatched++;
                        $display("FAIL rand result: {cout,sum}=%h required %h", {bus.cout, bus.sum}, exp);
                    end
`ifdef SOMA_OVERFLOW_EN
                    else if (bus.ovf !== eo) begin
                        mismatched++;
                        $display("FAIL rand ovf: got %b required %b", bus.ovf, eo);
                    end
`endif
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(ref_add(bus.a, bus.b, bus.cin));
                qo.push_back(ref_ovf(bus.a, bus.b, bus.cin));
                acc++;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        compared++;
        if (acc != 1000 || q.size() != 0) begin
            mismatched++;
            $display("FAIL rand completion: accepted %0d pending %0d required 1000/0", acc, q.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
